// File: rtl/load_store_unit.sv
// Load/store sequencer between execute and a word-wide data memory: sub-word stores use read-modify-write.
// Define LSU_ALIGN_CHECK_EN to reject misaligned/illegal accesses with err; otherwise they execute aligned down / as W.
module load_store_unit #(
    parameter int W = 32,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         we,
    input  logic [2:0]   funct3,
    input  logic [N+1:0] addr,
    input  logic [W-1:0] wdata,
    output logic         ready,
    output logic         done,
    output logic         err,
    output logic [W-1:0] rdata,
    output logic [N-1:0] address,
    output logic         MemRead,
    output logic         MemWrite,
    output logic [W-1:0] write_data,
    input  logic [W-1:0] read_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef LSU_ALIGN_CHECK_EN
    localparam logic [2:0] S_ERR   = 3'd5;
`endif

    logic [2:0]   state_q, state_d;
    logic         we_q, we_d;
    logic [2:0]   funct3_q, funct3_d;
    logic [N+1:0] addr_q, addr_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic [W-1:0] rdata_q, rdata_d;
    logic [W-1:0] wr_data_q, wr_data_d;

    logic [2:0]   accept_state;
    logic         is_byte, is_half;
    logic [7:0]   byte_lane;
    logic [15:0]  half_lane;
    logic [W-1:0] load_val;
    logic [W-1:0] merged;
    logic [W-1:0] wr_word;

    // Only the low two funct3 bits pick the size; codes 01x/11x fall into the word path.
    assign is_byte = (funct3_q[1:0] == 2'b00);
    assign is_half = (funct3_q[1:0] == 2'b01);

    always_comb begin
        accept_state = (!we || !funct3[1]) ? S_RD : S_WR;
`ifdef LSU_ALIGN_CHECK_EN
        if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
            (we && funct3[2]) ||
            ((funct3[1:0] == 2'b01) && addr[0]) ||
            ((funct3 == 3'b010) && (addr[1:0] != 2'b00)))
            accept_state = S_ERR;
`endif
    end

    always_comb begin
        byte_lane = read_data[{addr_q[1:0], 3'b000} +: 8];
        half_lane = read_data[{addr_q[1], 4'b0000} +: 16];
        if (is_byte)
            load_val = funct3_q[2] ? {{(W-8){1'b0}}, byte_lane}
                                   : {{(W-8){byte_lane[7]}}, byte_lane};
        else if (is_half)
            load_val = funct3_q[2] ? {{(W-16){1'b0}}, half_lane}
                                   : {{(W-16){half_lane[15]}}, half_lane};
        else
            load_val = read_data;

        merged = read_data;
        if (is_half)
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign MemRead    = (state_q == S_RD);
    assign MemWrite   = (state_q == S_WR) || ((state_q == S_MERGE) && we_q);
    assign wr_word    = (state_q == S_WR) ? wdata_q : merged;
    assign write_data = MemWrite ? wr_word : wr_data_q;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d     = we;
                    funct3_d = funct3;
                    addr_d   = addr;
                    wdata_d  = wdata;
                    state_d  = accept_state;
                end
            end
            S_RD:    state_d = S_MERGE;
            S_MERGE: begin
                if (!we_q)
                    rdata_d = load_val;
                state_d = S_DONE;
            end
            S_WR:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (MemWrite)
            wr_data_d = wr_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef LSU_ALIGN_CHECK_EN
    assign err = (state_q == S_ERR);
`else
    assign err = 1'b0;
`endif
    assign done    = (state_q == S_DONE) || err;
    assign ready   = (state_q == S_IDLE);
    assign rdata   = rdata_q;
    assign address = addr_q[N+1:2];

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the core's execute stage and the word-wide data memory. It turns byte, halfword and word loads and stores into word accesses, and implements sub-word stores as read-modify-write. It sign- or zero-extends load results and flags misaligned or illegal accesses. It sits directly upstream of the data memory and drives that memory's address, read-enable, write-enable and write-data inputs.

## Interface
- W, 32: data width; must be 32 (four byte lanes)
- N, 5: memory word-address width; the byte address is N+2 bits
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  1  core request; sampled only while ready=1
- we  in  1  1 = store, 0 = load
- funct3  in  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  N+2  byte address
- wdata  in  W  store data, right-justified
- ready  out  1  unit idle, request will be accepted
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; access rejected
- rdata  out  W  extended load result; valid from done onward until the next accept
- address  out  N  memory word index, equal to addr[N+1:2] of the accepted request
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- write_data  out  W  memory write data
- read_data  in  W  memory read data; registered, valid the cycle after MemRead

## Operation
- Little-endian. Byte lane = addr[1:0]; halfword lane = addr[1].
- A request is accepted on a rising edge where ready=1 and req=1. At that edge the unit latches we, funct3, addr and wdata. req is ignored in every other state.
- FSM states and transitions:
  - IDLE (ready=1). On accept:
    - illegal access → ERR
    - load → RD
    - word store → WR
    - byte or halfword store → RD
  - RD: MemRead=1 → MERGE.
  - MERGE, load: rdata ← extracted lane, extended → DONE.
  - MERGE, store: MemWrite=1, write_data = read_data with the target lane replaced by wdata[7:0] (byte) or wdata[15:0] (halfword) → DONE.
  - WR: MemWrite=1, write_data = wdata → DONE.
  - ERR: done=1, err=1, no memory access → IDLE.
  - DONE: done=1, err=0 → IDLE.
- Load extension:
  - B and H sign-extend from bit 7 or bit 15.
  - BU and HU zero-extend.
  - W passes the word through.
- Illegal access:
  - H/HU with addr[0]=1
  - W with addr[1:0]≠0
  - funct3 011, 110 or 111
  - a store with funct3[2]=1
  - (subject to Configuration)
- MemRead and MemWrite are never asserted together, and each is never high for more than one cycle per request.
- address holds the latched word index; write_data holds its last value outside write cycles.

## Timing
- Cycle 0 is the accept edge. done is asserted in:
  - cycle 3: loads and sub-word stores
  - cycle 2: word stores
  - cycle 1: illegal accesses
- Throughput: ready returns the cycle after done, so requests must be spaced at least one cycle apart.
- Reset values: ready=1 (state IDLE); done, err, MemRead, MemWrite = 0; rdata, address, write_data = 0.
- Reset asserted mid-operation: the FSM goes to IDLE immediately and MemRead/MemWrite deassert asynchronously. An in-flight sub-word store reset before MERGE writes nothing. No done pulse is issued for the aborted request.
- rdata is not modified by stores or errors.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - illegal-access detection as specified above
  - err is driven
- LSU_ALIGN_CHECK_EN undefined:
  - err is tied to 0
  - the ERR state is removed
  - misaligned H/W accesses ignore the low address bits (aligned down)
  - illegal funct3 codes execute as W

## Test plan
- SW, addr 0x08, wdata 0xDEADBEEF → cycle 1: MemWrite=1, address=2, write_data=0xDEADBEEF; cycle 2: done=1, err=0; MemRead never asserted.
- Loads from that word:
  - LB 0x0B → rdata 0xFFFFFFDE
  - LBU 0x0B → 0x000000DE
  - LH 0x0A → 0xFFFFDEAD
  - LHU 0x0A → 0x0000DEAD
  - LW 0x08 → 0xDEADBEEF
  - each: MemRead in cycle 1, done in cycle 3.
- SB 0x09, wdata 0x00000055 → MemRead in cycle 1, MemWrite in cycle 2 with write_data 0xDEAD55EF, done in cycle 3; a subsequent LW 0x08 returns 0xDEAD55EF.
- LW 0x06:
  - macro defined: done=1, err=1 in cycle 1; no MemRead or MemWrite.
  - macro undefined: reads word index 1, err=0.
- SB 0x09 with rst low in cycle 2: no MemWrite; ready=1 after release; LW 0x08 still returns the prior word.
- req held high across two SW requests: second accepted on the first edge after done, with ready high; both writes land.
